// File: rtl/melody_sequencer_pkg.sv
// Shared definitions for the melody sequencer and the tone stage it drives.
package melody_sequencer_pkg;

    localparam int unsigned CLK_FRQ_DEFAULT = 125_000_000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_PLAY,
        S_GAP,
        S_ADVANCE
    } state_e;

endpackage

// File: rtl/tick_gen.sv
// Duration time base: one-cycle tick every CLK_FRQ/TICK_HZ clocks, restartable via clr.
module tick_gen
    import melody_sequencer_pkg::*;
#(
    parameter int unsigned CLK_FRQ = CLK_FRQ_DEFAULT,
    parameter int unsigned TICK_HZ = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    localparam int unsigned DIV   = CLK_FRQ / TICK_HZ;
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // tick is not gated by clr: the cycle that ends a note uses tick and raises clr together
    assign tick = (cnt_q == TERMINAL);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/melody_sequencer.sv
// Walks an external note table and drives freq/output_enable for the tone stage, with inter-note gaps.
module melody_sequencer
    import melody_sequencer_pkg::*;
#(
    parameter int unsigned CLK_FRQ   = CLK_FRQ_DEFAULT,
    parameter int unsigned TICK_HZ   = 1000,
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned GAP_TICKS = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [23:0]       note_freq,
    input  logic [15:0]       note_dur,
    output logic [23:0]       freq,
    output logic              output_enable,
    output logic              busy,
    output logic              done
);
    localparam int unsigned GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_TICKS);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [23:0]        freq_q, freq_d;
    logic               oe_q, oe_d;
    logic [15:0]        dur_q, dur_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               done_q, done_d;
    logic               end_song;
    logic               tick;
    logic               tick_clr;

    // Restart the prescaler on entry so the first tick is one full period later
    assign tick_clr = (state_d != state_q) && ((state_d == S_PLAY) || (state_d == S_GAP));

    tick_gen #(
        .CLK_FRQ(CLK_FRQ),
        .TICK_HZ(TICK_HZ)
    ) u_tick_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (tick_clr),
        .tick (tick)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        freq_d   = freq_q;
        oe_d     = oe_q;
        dur_d    = dur_q;
        gap_d    = gap_q;
        done_d   = 1'b0;
        end_song = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                freq_d = '0;
                oe_d   = 1'b0;
                if (start) begin
                    addr_d  = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                if (note_dur == 16'd0) begin
                    end_song = 1'b1;
                end else begin
                    freq_d  = note_freq;
                    oe_d    = (note_freq != 24'd0);
                    dur_d   = note_dur;
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                if (tick) begin
                    dur_d = dur_q - 16'd1;
                    if (dur_q == 16'd1) begin
                        freq_d = '0;
                        oe_d   = 1'b0;
                        if (GAP_TICKS > 0) begin
                            gap_d   = GAP_LOAD;
                            state_d = S_GAP;
                        end else begin
                            state_d = S_ADVANCE;
                        end
                    end
                end
            end
            S_GAP: begin
                if (tick) begin
                    gap_d = gap_q - GAP_W'(1);
                    if (gap_q == GAP_W'(1)) begin
                        state_d = S_ADVANCE;
                    end
                end
            end
            S_ADVANCE: begin
                // The last table slot ends the song instead of wrapping to address 0
                if (&addr_q) begin
                    end_song = 1'b1;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (end_song) begin
            if (loop_en) begin
                addr_d  = '0;
                state_d = S_FETCH;
            end else begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
        end

        // stop overrides everything, including start and end-of-song handling
        if (stop) begin
            state_d = S_IDLE;
            freq_d  = '0;
            oe_d    = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            freq_q  <= '0;
            oe_q    <= 1'b0;
            dur_q   <= '0;
            gap_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            freq_q  <= freq_d;
            oe_q    <= oe_d;
            dur_q   <= dur_d;
            gap_q   <= gap_d;
            done_q  <= done_d;
        end
    end

    assign mem_addr      = addr_q;
    assign freq          = freq_q;
    assign output_enable = oe_q;
    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;

endmodule
